// File: rtl/enigma_pkg.sv
// Shared constants, FSM state type and rotor-position helpers for the keypress front end.
package enigma_pkg;
  localparam int ALPHA_SIZE  = 26;
  localparam int POS_W       = 5;
  localparam int NOTCH_R_DEF = 16;
  localparam int NOTCH_M_DEF = 4;

  typedef enum logic [2:0] {IDLE, DEB_PRESS, STEP, CAPTURE, DEB_RELEASE} step_state_t;

  function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
    return (p == POS_W'(ALPHA_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  // Out-of-range load values collapse to position 0.
  function automatic logic [POS_W-1:0] pos_legal(input logic [POS_W-1:0] p);
    return (p > POS_W'(ALPHA_SIZE - 1)) ? '0 : p;
  endfunction
endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser for the raw key plus a run-length counter that flags the
// DEBOUNCE_CYCLES-th consecutive sample at the level the FSM is waiting for.
module key_debouncer
  import enigma_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  input  logic run,
  input  logic target,
  output logic key_s,
  output logic pressed,
  output logic released
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_m;
  logic [CNT_W-1:0] count;
  logic             stable;

  // count holds matching samples already seen, so this cycle's sample completes the run
  assign stable   = run && (key_s == target) && (count == CNT_LAST);
  assign pressed  = stable && !target;
  assign released = stable &&  target;

  always_ff @(posedge clock) begin
    if (reset) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
      count <= '0;
    end else begin
      key_m <= key_n;
      key_s <= key_m;
      if (!run || (key_s != target) || stable) count <= '0;
      else if (count != CNT_MAX)               count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/rotor_step_controller.sv
// Keypress front end: debounced key drives a three-rotor odometer with notch carry and
// double step, emitting rotate pulses then a capture strobe once per accepted press.
module rotor_step_controller
  import enigma_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NOTCH_R         = NOTCH_R_DEF,
  parameter int NOTCH_M         = NOTCH_M_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_n,
  input  logic             load,
  input  logic [POS_W-1:0] load_pos_r,
  input  logic [POS_W-1:0] load_pos_m,
  input  logic [POS_W-1:0] load_pos_l,
  output logic [POS_W-1:0] pos_r,
  output logic [POS_W-1:0] pos_m,
  output logic [POS_W-1:0] pos_l,
  output logic             rotate_r,
  output logic             rotate_m,
  output logic             rotate_l,
  output logic             capture,
  output logic             busy
);
  step_state_t state;
  logic        key_s, pressed, released;
  logic        deb_run, deb_target;
  logic        at_notch_r, at_notch_m;

  assign at_notch_r = (pos_r == POS_W'(NOTCH_R));
  assign at_notch_m = (pos_m == POS_W'(NOTCH_M));
  // A load in IDLE holds the press counter so the press is seen from the next cycle
  assign deb_run    = ((state == IDLE) && !load) || (state == DEB_PRESS) || (state == DEB_RELEASE);
  assign deb_target = (state == DEB_RELEASE);
  assign busy       = (state != IDLE);

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clock    (clock),
    .reset    (reset),
    .key_n    (key_n),
    .run      (deb_run),
    .target   (deb_target),
    .key_s    (key_s),
    .pressed  (pressed),
    .released (released)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      pos_r    <= '0;
      pos_m    <= '0;
      pos_l    <= '0;
      rotate_r <= 1'b0;
      rotate_m <= 1'b0;
      rotate_l <= 1'b0;
      capture  <= 1'b0;
    end else begin
      rotate_r <= 1'b0;
      rotate_m <= 1'b0;
      rotate_l <= 1'b0;
      capture  <= 1'b0;
      unique case (state)
        IDLE, DEB_PRESS: begin
          if ((state == IDLE) && load) begin
            pos_r <= pos_legal(load_pos_r);
            pos_m <= pos_legal(load_pos_m);
            pos_l <= pos_legal(load_pos_l);
          end else if (pressed) begin
            // Middle also steps when it sits on its own notch: the double step
            state    <= STEP;
            rotate_r <= 1'b1;
            rotate_m <= at_notch_r | at_notch_m;
            rotate_l <= at_notch_m;
          end else if (key_s) begin
            state <= IDLE;
          end else begin
            state <= DEB_PRESS;
          end
        end
        STEP: begin
          pos_r <= pos_inc(pos_r);
          if (rotate_m) pos_m <= pos_inc(pos_m);
          if (rotate_l) pos_l <= pos_inc(pos_l);
          capture <= 1'b1;
          state   <= CAPTURE;
        end
        CAPTURE:     state <= DEB_RELEASE;
        DEB_RELEASE: if (released) state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rotor_step_controller.sv
// Bench for rotor_step_controller: directed timing scenarios plus random presses checked
// against an odometer model built from the stepping rules.
module tb_rotor_step_controller;
  localparam int D  = 4;
  localparam int NR = 16;
  localparam int NM = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_n = 1'b1;
  logic       load  = 1'b0;
  logic [4:0] load_pos_r = '0, load_pos_m = '0, load_pos_l = '0;
  logic [4:0] pos_r, pos_m, pos_l;
  logic       rotate_r, rotate_m, rotate_l, capture, busy;

  int n_checks = 0, n_fail = 0;
  int n_rot_r = 0, n_rot_m = 0, n_rot_l = 0, n_cap = 0, n_ml = 0;
  int b_r, b_m, b_l, b_c, b_ml;
  int er = 0, em = 0, el = 0;

  rotor_step_controller #(.DEBOUNCE_CYCLES(D), .NOTCH_R(NR), .NOTCH_M(NM)) dut (
    .clock(clock), .reset(reset), .key_n(key_n), .load(load),
    .load_pos_r(load_pos_r), .load_pos_m(load_pos_m), .load_pos_l(load_pos_l),
    .pos_r(pos_r), .pos_m(pos_m), .pos_l(pos_l),
    .rotate_r(rotate_r), .rotate_m(rotate_m), .rotate_l(rotate_l),
    .capture(capture), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rotate_r === 1'b1) n_rot_r++;
    if (rotate_m === 1'b1) n_rot_m++;
    if (rotate_l === 1'b1) n_rot_l++;
    if (capture  === 1'b1) n_cap++;
    if (rotate_m === 1'b1 && rotate_l === 1'b1) n_ml++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic snap;
    b_r = n_rot_r; b_m = n_rot_m; b_l = n_rot_l; b_c = n_cap; b_ml = n_ml;
  endtask

  task automatic do_load(input int r, input int m, input int l);
    load = 1'b1; load_pos_r = 5'(r); load_pos_m = 5'(m); load_pos_l = 5'(l);
    cycles(1);
    load = 1'b0;
    er = (r > 25) ? 0 : r; em = (m > 25) ? 0 : m; el = (l > 25) ? 0 : l;
  endtask

  task automatic press(input int len);
    key_n = 1'b0; cycles(len);
    key_n = 1'b1; cycles(D + 8);
  endtask

  // Odometer reference: right always advances, notches carry, middle on its notch drags itself
  task automatic model_step(output bit sm, output bit sl);
    sm = (er == NR) || (em == NM);
    sl = (em == NM);
    er = (er + 1) % 26;
    if (sm) em = (em + 1) % 26;
    if (sl) el = (el + 1) % 26;
  endtask

  task automatic test_reset;
    reset = 1'b1; key_n = 1'b1; load = 1'b0;
    cycles(3);
    @(negedge clock);
    n_checks++;
    if ({pos_l, pos_m, pos_r, rotate_r, rotate_m, rotate_l, capture, busy} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {pos_l, pos_m, pos_r, rotate_r, rotate_m, rotate_l, capture, busy});
    end
    @(posedge clock); #1 reset = 1'b0;
    cycles(3);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b want 0", busy); end
    er = 0; em = 0; el = 0;
  endtask

  // Key low just after edge 0, released after edge 20: key_s falls at edge 2, STEP at 2+D
  task automatic test_single_press;
    logic [19:0] got, want;
    @(posedge clock); #1 key_n = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clock); #1;
      if (k == 20) key_n = 1'b1;
      @(negedge clock);
      got  = {rotate_r, rotate_m, rotate_l, capture, busy, pos_l, pos_m, pos_r};
      want = {k == 2 + D, 1'b0, 1'b0, k == 3 + D, (k >= 3) && (k < 22 + D),
              5'd0, 5'd0, (k >= 3 + D) ? 5'd1 : 5'd0};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL single_press cycle %0d: got %h want %h", k, got, want);
      end
    end
    er = 1;
  endtask

  task automatic test_glitch;
    snap();
    key_n = 1'b0; cycles(2);
    key_n = 1'b1; cycles(1);
    key_n = 1'b0; cycles(2);
    key_n = 1'b1; cycles(D + 8);
    n_checks++;
    if ({n_rot_r - b_r, n_rot_m - b_m, n_rot_l - b_l, n_cap - b_c} !== 128'd0) begin
      n_fail++;
      $display("FAIL glitch_pulses: r=%0d m=%0d l=%0d cap=%0d want all 0",
               n_rot_r - b_r, n_rot_m - b_m, n_rot_l - b_l, n_cap - b_c);
    end
    n_checks++;
    if ({busy, pos_l, pos_m, pos_r} !== {1'b0, 5'd0, 5'd0, 5'd1}) begin
      n_fail++;
      $display("FAIL glitch_state: busy=%b l=%0d m=%0d r=%0d want 0/0/0/1", busy, pos_l, pos_m, pos_r);
    end
  endtask

  task automatic test_wrap;
    do_load(25, 0, 0);
    snap(); press(D + 4);
    n_checks++;
    if ({pos_l, pos_m, pos_r} !== 15'd0) begin
      n_fail++; $display("FAIL wrap_pos: l=%0d m=%0d r=%0d want 0/0/0", pos_l, pos_m, pos_r);
    end
    n_checks++;
    if ({n_rot_r - b_r, n_rot_m - b_m, n_cap - b_c} !== {32'd1, 32'd0, 32'd1}) begin
      n_fail++;
      $display("FAIL wrap_pulses: r=%0d m=%0d cap=%0d want 1/0/1", n_rot_r - b_r, n_rot_m - b_m, n_cap - b_c);
    end
    er = 0;
  endtask

  task automatic test_double_step;
    do_load(16, 3, 0);
    snap(); press(D + 2);
    n_checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd0, 5'd4, 5'd17} ||
        {n_rot_m - b_m, n_rot_l - b_l} !== {32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL carry_first: l=%0d m=%0d r=%0d rm=%0d rl=%0d want 0/4/17 1/0",
               pos_l, pos_m, pos_r, n_rot_m - b_m, n_rot_l - b_l);
    end
    snap(); press(D + 2);
    n_checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd1, 5'd5, 5'd18}) begin
      n_fail++; $display("FAIL double_step_pos: l=%0d m=%0d r=%0d want 1/5/18", pos_l, pos_m, pos_r);
    end
    n_checks++;
    if ({n_rot_r - b_r, n_rot_m - b_m, n_rot_l - b_l, n_ml - b_ml} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL double_step_pulses: r=%0d m=%0d l=%0d together=%0d want 1/1/1/1",
               n_rot_r - b_r, n_rot_m - b_m, n_rot_l - b_l, n_ml - b_ml);
    end
    er = 18; em = 5; el = 1;
  endtask

  task automatic test_middle_wrap;
    do_load(0, 25, 25);
    snap(); press(D + 1);
    n_checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd25, 5'd25, 5'd1} || (n_rot_m - b_m) != 0) begin
      n_fail++;
      $display("FAIL mid25_nostep: l=%0d m=%0d r=%0d rm=%0d want 25/25/1 0", pos_l, pos_m, pos_r, n_rot_m - b_m);
    end
    do_load(16, 25, 25);
    snap(); press(D + 1);
    n_checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd25, 5'd0, 5'd17} || {n_rot_m - b_m, n_rot_l - b_l} !== {32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL mid_wrap: l=%0d m=%0d r=%0d rm=%0d rl=%0d want 25/0/17 1/0",
               pos_l, pos_m, pos_r, n_rot_m - b_m, n_rot_l - b_l);
    end
    er = 17; em = 0; el = 25;
  endtask

  // Clamp of illegal loads, then a load coinciding with the first low key_s sample
  task automatic test_load_race;
    logic [1:0] got, want;
    do_load(31, 26, 30);
    n_checks++;
    if ({pos_l, pos_m, pos_r} !== 15'd0) begin
      n_fail++; $display("FAIL load_clamp: l=%0d m=%0d r=%0d want 0/0/0", pos_l, pos_m, pos_r);
    end
    @(posedge clock); #1 key_n = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clock); #1;
      if (k == 2) begin load = 1'b1; load_pos_r = 5'd7; load_pos_m = 5'd8; load_pos_l = 5'd9; end
      if (k == 3) load = 1'b0;
      if (k == 12) key_n = 1'b1;
      @(negedge clock);
      got  = {rotate_r, capture};
      want = {k == 3 + D, k == 4 + D};
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL load_race cycle %0d: rot/cap got %b want %b", k, got, want);
      end
    end
    cycles(D + 8);
    n_checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd9, 5'd8, 5'd8}) begin
      n_fail++; $display("FAIL load_race_pos: l=%0d m=%0d r=%0d want 9/8/8", pos_l, pos_m, pos_r);
    end
    er = 8; em = 8; el = 9;
  endtask

  task automatic test_reset_in_step;
    do_load(5, 6, 7);
    @(posedge clock); #1 key_n = 1'b0;
    for (int k = 1; k <= 2 + D; k++) begin
      @(posedge clock); #1;
      if (k == 2 + D) begin reset = 1'b1; key_n = 1'b1; end
      @(negedge clock);
      if (k == 2 + D) begin
        n_checks++;
        if ({rotate_r, busy} !== 2'b11) begin
          n_fail++; $display("FAIL step_entry: rotate_r=%b busy=%b want 1/1", rotate_r, busy);
        end
      end
    end
    @(posedge clock); #1;
    @(negedge clock);
    n_checks++;
    if ({pos_l, pos_m, pos_r, rotate_r, rotate_m, rotate_l, capture, busy} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_in_step: got %h want 0", {pos_l, pos_m, pos_r, rotate_r, rotate_m, rotate_l, capture, busy});
    end
    @(posedge clock); #1 reset = 1'b0;
    snap(); cycles(D + 10);
    n_checks++;
    if ({n_rot_r - b_r, n_cap - b_c} !== 64'd0 || {busy, pos_l, pos_m, pos_r} !== 16'd0) begin
      n_fail++;
      $display("FAIL after_abort: rot=%0d cap=%0d busy=%b pos=%0d/%0d/%0d want 0",
               n_rot_r - b_r, n_cap - b_c, busy, pos_l, pos_m, pos_r);
    end
    er = 0; em = 0; el = 0;
  endtask

  task automatic test_load_while_busy;
    do_load(2, 2, 2);
    key_n = 1'b0; cycles(4);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_press: busy=%b want 1", busy); end
    load = 1'b1; load_pos_r = 5'd10; load_pos_m = 5'd10; load_pos_l = 5'd10;
    cycles(1); load = 1'b0;
    cycles(8); key_n = 1'b1; cycles(3);
    load = 1'b1; cycles(1); load = 1'b0;
    cycles(D + 6);
    n_checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd2, 5'd2, 5'd3}) begin
      n_fail++; $display("FAIL load_ignored: l=%0d m=%0d r=%0d want 2/2/3", pos_l, pos_m, pos_r);
    end
    er = 3; em = 2; el = 2;
  endtask

  task automatic test_random;
    bit sm, sl, glitch;
    int len, exp_r;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 2) == 0)
        do_load($urandom_range(0, 1) ? NR : int'($urandom_range(0, 31)),
                $urandom_range(0, 1) ? int'($urandom_range(NM - 1, NM)) : int'($urandom_range(0, 31)),
                $urandom_range(0, 31));
      glitch = ($urandom_range(0, 2) == 0);
      len    = glitch ? $urandom_range(1, D - 1) : $urandom_range(D, D + 6);
      snap(); press(len);
      sm = 1'b0; sl = 1'b0; exp_r = 0;
      if (!glitch) begin model_step(sm, sl); exp_r = 1; end
      n_checks++;
      if ({pos_l, pos_m, pos_r} !== {5'(el), 5'(em), 5'(er)}) begin
        n_fail++;
        $display("FAIL rand%0d_pos: l=%0d m=%0d r=%0d want %0d/%0d/%0d", it, pos_l, pos_m, pos_r, el, em, er);
      end
      n_checks++;
      if ({n_rot_r - b_r, n_rot_m - b_m, n_rot_l - b_l, n_cap - b_c} !== {exp_r, int'(sm), int'(sl), exp_r}) begin
        n_fail++;
        $display("FAIL rand%0d_pulses: r=%0d m=%0d l=%0d cap=%0d want %0d/%0d/%0d/%0d", it,
                 n_rot_r - b_r, n_rot_m - b_m, n_rot_l - b_l, n_cap - b_c, exp_r, sm, sl, exp_r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_wrap();
    test_double_step();
    test_middle_wrap();
    test_load_race();
    test_reset_in_step();
    test_load_while_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
